// File: rtl/alu_md_if.sv
// Request/response bundle for the execute unit.
// Handshake: the master raises start with the decode fields and operands
// for one cycle while busy is low; the unit accepts it on that edge, raises
// busy until its DONE cycle ends, pulses done for exactly one cycle, and
// holds result/illegal until the next accepted start. A start seen while
// busy is high is dropped, never queued.
interface alu_md_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [1:0]      ALUOp;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [6:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic            illegal;

    modport master (
        output start, ALUOp, funct3, funct7, op, a, b,
        input  busy, done, result, illegal
    );

    modport slave (
        input  start, ALUOp, funct3, funct7, op, a, b,
        output busy, done, result, illegal
    );
endinterface

// File: rtl/alu_md_unit.sv
// Execute unit: single-cycle RV base ALU ops plus iterative M-extension
// multiply (shift-add) and divide (restoring), one bit per cycle.
module alu_md_unit #(
    parameter int XLEN = 32
) (
    input  logic        clk,
    input  logic        rst,
    alu_md_if.slave     bus,
    output logic [1:0]  o_state
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ITER  = 2'd1,
        S_FIXUP = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    typedef enum logic [4:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA,
        OP_SLT, OP_SLTU, OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
        OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_ILL
    } op_e;

    state_e            r_state;
    op_e               r_op;
    logic [CW-1:0]     r_cnt;
    logic              r_neg;      // product / quotient needs negation
    logic              r_neg_rem;  // remainder needs negation
    logic [2*XLEN-1:0] r_acc;      // product accumulator
    logic [2*XLEN-1:0] r_mcand;    // shifted multiplicand
    logic [XLEN-1:0]   r_opb;      // multiplier (shifts) or divisor (static)
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_quo;      // dividend shifts out as quotient shifts in
    logic              r_busy;
    logic              r_done;
    logic [XLEN-1:0]   r_result;
    logic              r_illegal;

    op_e               w_op;
    logic [CW-1:0]     w_shamt;
    logic [XLEN-1:0]   w_alu;
    logic              w_is_mul;
    logic              w_is_div;
    logic              w_div_b0;
    logic              w_div_ovf;
    logic              w_iter;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic [XLEN:0]     w_div_shift;
    logic [XLEN:0]     w_div_diff;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo_s;
    logic [XLEN-1:0]   w_rem_s;
    logic [XLEN-1:0]   w_fix_res;

    // Decode ALUOp/funct3/funct7/op into an internal operation.
    always_comb begin
        w_op = OP_ADD;
        case (bus.ALUOp)
            2'b00: w_op = OP_ADD;
            2'b01: w_op = OP_SUB;
            2'b10: begin
                if (bus.funct7 == 7'b0000001 && bus.op[5]) begin
                    case (bus.funct3)
                        3'b000:  w_op = OP_MUL;
                        3'b001:  w_op = OP_MULH;
                        3'b010:  w_op = OP_MULHSU;
                        3'b011:  w_op = OP_MULHU;
                        3'b100:  w_op = OP_DIV;
                        3'b101:  w_op = OP_DIVU;
                        3'b110:  w_op = OP_REM;
                        default: w_op = OP_REMU;
                    endcase
                end else if (bus.op[5] && bus.funct7 != 7'b0000000 &&
                             bus.funct7 != 7'b0100000) begin
                    w_op = OP_ILL;
                end else begin
                    case (bus.funct3)
                        3'b000:  w_op = (bus.funct7[5] & bus.op[5]) ? OP_SUB : OP_ADD;
                        3'b001:  w_op = OP_SLL;
                        3'b010:  w_op = OP_SLT;
                        3'b011:  w_op = OP_SLTU;
                        3'b100:  w_op = OP_XOR;
                        3'b101:  w_op = bus.funct7[5] ? OP_SRA : OP_SRL;
                        3'b110:  w_op = OP_OR;
                        default: w_op = OP_AND;
                    endcase
                end
            end
            default: w_op = OP_ILL;
        endcase
    end

    // Operand conditioning: signs, magnitudes and divide special cases.
    always_comb begin
        w_is_mul  = w_op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
        w_is_div  = w_op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
        w_div_b0  = w_is_div && (bus.b == '0);
        w_div_ovf = (w_op inside {OP_DIV, OP_REM}) &&
                    (bus.a == {1'b1, {(XLEN-1){1'b0}}}) && (&bus.b);
        w_iter    = w_is_mul || (w_is_div && !w_div_b0 && !w_div_ovf);
        w_a_neg   = (w_op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && bus.a[XLEN-1];
        w_b_neg   = (w_op inside {OP_MULH, OP_DIV, OP_REM}) && bus.b[XLEN-1];
        w_a_mag   = w_a_neg ? (~bus.a + 1'b1) : bus.a;
        w_b_mag   = w_b_neg ? (~bus.b + 1'b1) : bus.b;
    end

    // Single-cycle results, including illegal (0) and divide special cases.
    always_comb begin
        w_shamt = bus.b[CW-1:0];
        w_alu   = '0;
        case (w_op)
            OP_ADD:  w_alu = bus.a + bus.b;
            OP_SUB:  w_alu = bus.a - bus.b;
            OP_AND:  w_alu = bus.a & bus.b;
            OP_OR:   w_alu = bus.a | bus.b;
            OP_XOR:  w_alu = bus.a ^ bus.b;
            OP_SLL:  w_alu = bus.a << w_shamt;
            OP_SRL:  w_alu = bus.a >> w_shamt;
            OP_SRA:  w_alu = $signed(bus.a) >>> w_shamt;
            OP_SLT:  w_alu = {{(XLEN-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OP_SLTU: w_alu = {{(XLEN-1){1'b0}}, (bus.a < bus.b)};
            OP_DIV, OP_DIVU: w_alu = w_div_b0 ? {XLEN{1'b1}} : bus.a;
            OP_REM, OP_REMU: w_alu = w_div_b0 ? bus.a : '0;
            default: w_alu = '0;
        endcase
    end

    // One restoring-division step and the final sign correction.
    always_comb begin
        w_div_shift = {r_rem, r_quo[XLEN-1]};
        w_div_diff  = w_div_shift - {1'b0, r_opb};
        w_prod      = r_neg ? (~r_acc + 1'b1) : r_acc;
        w_quo_s     = r_neg ? (~r_quo + 1'b1) : r_quo;
        w_rem_s     = r_neg_rem ? (~r_rem + 1'b1) : r_rem;
        case (r_op)
            OP_MUL:                        w_fix_res = w_prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  w_fix_res = w_prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               w_fix_res = w_quo_s;
            default:                       w_fix_res = w_rem_s;
        endcase
    end

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_op      <= OP_ADD;
            r_cnt     <= '0;
            r_neg     <= 1'b0;
            r_neg_rem <= 1'b0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_opb     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_result  <= '0;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_busy <= 1'b1;
                        if (w_iter) begin
                            r_state   <= S_ITER;
                            r_op      <= w_op;
                            r_cnt     <= CW'(XLEN-1);
                            r_neg     <= w_a_neg ^ w_b_neg;
                            r_neg_rem <= w_a_neg;
                            r_acc     <= '0;
                            r_mcand   <= {{XLEN{1'b0}}, w_a_mag};
                            r_opb     <= w_b_mag;
                            r_rem     <= '0;
                            r_quo     <= w_a_mag;
                        end else begin
                            r_state   <= S_DONE;
                            r_done    <= 1'b1;
                            r_result  <= w_alu;
                            r_illegal <= (w_op == OP_ILL);
                        end
                    end
                end
                S_ITER: begin
                    if (r_op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU}) begin
                        if (r_opb[0]) begin
                            r_acc <= r_acc + r_mcand;
                        end
                        r_mcand <= r_mcand << 1;
                        r_opb   <= r_opb >> 1;
                    end else if (!w_div_diff[XLEN]) begin
                        r_rem <= w_div_diff[XLEN-1:0];
                        r_quo <= {r_quo[XLEN-2:0], 1'b1};
                    end else begin
                        r_rem <= w_div_shift[XLEN-1:0];
                        r_quo <= {r_quo[XLEN-2:0], 1'b0};
                    end
                    if (r_cnt == '0) begin
                        r_state <= S_FIXUP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_FIXUP: begin
                    r_state   <= S_DONE;
                    r_done    <= 1'b1;
                    r_result  <= w_fix_res;
                    r_illegal <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.result  = r_result;
    assign bus.illegal = r_illegal;
    assign o_state     = r_state;
endmodule

// File: tb/tb_alu_md_unit.sv
// Self-checking bench for alu_md_unit: directed cases, reset and dropped
// start scenarios, then random operations against an arithmetic model.
module tb_alu_md_unit;
  localparam int XLEN = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] state;

  alu_md_if #(.XLEN(XLEN)) bus ();

  alu_md_unit #(.XLEN(XLEN)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .o_state (state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [XLEN-1:0] exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference model: results from plain arithmetic on the instruction rules
  function automatic void model(input logic [1:0] aluop, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [6:0] opc,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output logic ill, output int lat);
    logic signed [63:0] sa, sb;
    logic [63:0] ua, ub, asx, p;
    logic signed [31:0] q;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    asx = {{32{a[31]}}, a};
    res = 32'h0;
    ill = 1'b0;
    lat = 1;
    if (aluop == 2'b00) res = a + b;
    else if (aluop == 2'b01) res = a - b;
    else if (aluop == 2'b11) ill = 1'b1;
    else if (f7 == 7'b0000001 && opc[5]) begin
      case (f3)
        3'd0: begin p = ua * ub; res = p[31:0]; lat = 34; end
        3'd1: begin p = sa * sb; res = p[63:32]; lat = 34; end
        3'd2: begin p = asx * ub; res = p[63:32]; lat = 34; end
        3'd3: begin p = ua * ub; res = p[63:32]; lat = 34; end
        3'd4, 3'd6: begin
          if (b == 0) res = (f3 == 3'd4) ? 32'hFFFF_FFFF : a;
          else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = (f3 == 3'd4) ? a : 32'h0;
          else begin
            q = (f3 == 3'd4) ? ($signed(a) / $signed(b)) : ($signed(a) % $signed(b));
            res = q;
            lat = 34;
          end
        end
        default: begin
          if (b == 0) res = (f3 == 3'd5) ? 32'hFFFF_FFFF : a;
          else begin
            res = (f3 == 3'd5) ? (a / b) : (a % b);
            lat = 34;
          end
        end
      endcase
    end else if (opc[5] && f7 != 7'b0000000 && f7 != 7'b0100000) begin
      ill = 1'b1;
    end else begin
      case (f3)
        3'd0: res = (f7[5] && opc[5]) ? a - b : a + b;
        3'd1: res = a << b[4:0];
        3'd2: res = (sa < sb) ? 32'd1 : 32'd0;
        3'd3: res = (a < b) ? 32'd1 : 32'd0;
        3'd4: res = a ^ b;
        3'd5: res = f7[5] ? 32'(sa >>> b[4:0]) : (a >> b[4:0]);
        3'd6: res = a | b;
        default: res = a & b;
      endcase
    end
  endfunction

  // driver: issue one op, optionally pulse a stray start, then score it
  task automatic run_op(input string tag, input logic [1:0] aluop, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [6:0] opc,
                        input logic [31:0] a, input logic [31:0] b, input int glitch);
    logic [31:0] er, exp_r;
    logic ei;
    int el, lat;
    model(aluop, f3, f7, opc, a, b, er, ei, el);
    exp_q.push_back(er);
    for (int k = 0; k < 50 && bus.busy; k++) tick();
    bus.start = 1'b1; bus.ALUOp = aluop; bus.funct3 = f3; bus.funct7 = f7;
    bus.op = opc; bus.a = a; bus.b = b;
    tick();
    bus.start = 1'b0;
    bus.a = $urandom; bus.b = $urandom; bus.funct3 = 3'($urandom_range(0, 7));
    check({tag, "/busy"}, bus.busy, 1);
    lat = 1;
    while (!bus.done && lat < 100) begin
      if (lat == glitch) begin
        bus.start = 1'b1; bus.ALUOp = 2'b00;
      end
      tick();
      bus.start = 1'b0;
      lat++;
    end
    exp_r = exp_q.pop_front();
    check({tag, "/done"}, bus.done, 1);
    check({tag, "/lat"}, lat, el);
    check({tag, "/ill"}, bus.illegal, ei);
    if (!ei || aluop == 2'b11) check({tag, "/res"}, bus.result, exp_r);
    tick();
    check({tag, "/pulse"}, bus.done, 0);
    check({tag, "/idle"}, bus.busy, 0);
    if (!ei) check({tag, "/hold"}, bus.result, exp_r);
  endtask

  initial begin
    int seen;
    logic [1:0] ra;
    logic [6:0] rf7, rop;
    logic [31:0] rav, rbv;
    bus.start = 1'b0; bus.ALUOp = 2'b00; bus.funct3 = 3'd0; bus.funct7 = 7'd0;
    bus.op = 7'd0; bus.a = '0; bus.b = '0;
    rst = 1'b1;
    repeat (3) tick();
    check("rst/busy", bus.busy, 0);
    check("rst/done", bus.done, 0);
    check("rst/result", bus.result, 0);
    check("rst/illegal", bus.illegal, 0);
    check("rst/state", state, 0);
    rst = 1'b0;
    tick();

    run_op("sub_r",   2'b10, 3'b000, 7'b0100000, 7'b0110011, 32'd5, 32'd7, -1);
    run_op("addi",    2'b10, 3'b000, 7'b0100000, 7'b0010011, 32'd5, 32'd7, -1);
    run_op("sra",     2'b10, 3'b101, 7'b0100000, 7'b0110011, 32'h8000_0000, 32'd4, -1);
    run_op("srl",     2'b10, 3'b101, 7'b0000000, 7'b0110011, 32'h8000_0000, 32'd4, -1);
    run_op("mulh",    2'b10, 3'b001, 7'b0000001, 7'b0110011, 32'hFFFF_FFFF, 32'd2, -1);
    run_op("mulhu",   2'b10, 3'b011, 7'b0000001, 7'b0110011, 32'hFFFF_FFFF, 32'd2, -1);
    run_op("mul",     2'b10, 3'b000, 7'b0000001, 7'b0110011, 32'hFFFF_FFFF, 32'd2, -1);
    run_op("mulhsu",  2'b10, 3'b010, 7'b0000001, 7'b0110011, 32'hFFFF_FFFF, 32'd2, -1);
    run_op("div",     2'b10, 3'b100, 7'b0000001, 7'b0110011, -32'sd7, 32'd2, -1);
    run_op("rem",     2'b10, 3'b110, 7'b0000001, 7'b0110011, -32'sd7, 32'd2, -1);
    run_op("divu_b0", 2'b10, 3'b101, 7'b0000001, 7'b0110011, 32'd100, 32'd0, -1);
    run_op("rem_b0",  2'b10, 3'b110, 7'b0000001, 7'b0110011, 32'd100, 32'd0, -1);
    run_op("div_ovf", 2'b10, 3'b100, 7'b0000001, 7'b0110011, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    run_op("rem_ovf", 2'b10, 3'b110, 7'b0000001, 7'b0110011, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    run_op("slt",     2'b10, 3'b010, 7'b0000000, 7'b0110011, 32'hFFFF_FFFF, 32'd1, -1);
    run_op("sltu",    2'b10, 3'b011, 7'b0000000, 7'b0110011, 32'hFFFF_FFFF, 32'd1, -1);

    // reset in the middle of an iterative divide
    bus.start = 1'b1; bus.ALUOp = 2'b10; bus.funct3 = 3'b101; bus.funct7 = 7'b0000001;
    bus.op = 7'b0110011; bus.a = 32'd1000; bus.b = 32'd3;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst/busy", bus.busy, 0);
    check("midrst/done", bus.done, 0);
    check("midrst/result", bus.result, 0);
    check("midrst/illegal", bus.illegal, 0);
    check("midrst/state", state, 0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus.done) seen++;
    end
    check("midrst/nodone", seen, 0);
    run_op("add_after_rst", 2'b00, 3'b000, 7'b0000000, 7'b0110011, 32'd40, 32'd2, -1);

    // stray start during an iterative op is dropped
    run_op("divu_glitch", 2'b10, 3'b101, 7'b0000001, 7'b0110011, 32'd1000, 32'd3, 5);
    check("divu_glitch/333", bus.result, 333);

    run_op("aluop11", 2'b11, 3'b000, 7'b0000000, 7'b0110011, 32'd9, 32'd9, -1);
    run_op("bad_f7",  2'b10, 3'b100, 7'b0000010, 7'b0110011, 32'd9, 32'd9, -1);
    run_op("good_after_ill", 2'b10, 3'b110, 7'b0000000, 7'b0110011, 32'h0F0F_0000, 32'h00FF_00FF, -1);

    // random operations
    for (int n = 0; n < 48; n++) begin
      ra = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'b10;
      case ($urandom_range(0, 3))
        0: rf7 = 7'b0000000;
        1: rf7 = 7'b0100000;
        2: rf7 = 7'b0000001;
        default: rf7 = ($urandom_range(0, 1) == 0) ? 7'b0000001 : 7'($urandom);
      endcase
      rop = ($urandom_range(0, 3) == 0) ? 7'b0010011 : 7'b0110011;
      case ($urandom_range(0, 7))
        0: rav = 32'h8000_0000;
        1: rav = 32'hFFFF_FFFF;
        default: rav = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: rbv = 32'h0;
        1: rbv = 32'hFFFF_FFFF;
        2: rbv = 32'($urandom_range(1, 40));
        default: rbv = $urandom;
      endcase
      run_op("rand", ra, 3'($urandom_range(0, 7)), rf7, rop, rav, rbv, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_md_unit.md
# alu_md_unit

Parametrised multi-cycle execute unit replacing the purely combinational ALU control path. It decodes ALUOp/funct3/funct7/op internally and executes the RV base integer ALU operations in one cycle. It also executes the RV M-extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) iteratively, one bit per cycle. It sits in the execute stage and stalls the core through `busy` while an iterative operation is in flight.

## Interface
- `XLEN`, 32, datapath width; legal values 32 or 64; shift amount is `b[$clog2(XLEN)-1:0]`
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous reset, active-high
- `start`  in  1  request; sampled only in IDLE
- `ALUOp`  in  2  00 ADD, 01 SUB, 10 decode funct fields, 11 illegal
- `funct3`  in  3  instruction funct3
- `funct7`  in  7  instruction funct7
- `op`  in  7  opcode; `op[5]`=1 marks R-type
- `a`  in  XLEN  operand rs1
- `b`  in  XLEN  operand rs2/immediate
- `busy`  out  1  high while an operation is in flight; `start` ignored
- `done`  out  1  one-cycle pulse; `result` valid
- `result`  out  XLEN  held from `done` until the next accepted `start`
- `illegal`  out  1  qualified by `done`; undefined encoding

## Operation
- Decode with ALUOp=10:
  - funct7=0000001 and op[5]=1 → M-op selected by funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
  - Otherwise base op by funct3:
    - 000 → SUB if funct7[5]&op[5], else ADD.
    - 111 AND; 110 OR; 100 XOR; 001 SLL.
    - 101 → SRA if funct7[5], else SRL.
    - 010 SLT (signed); 011 SLTU.
  - Any base funct7 other than 0000000 or 0100000 on R-type → illegal.
- ALUOp=11 → illegal. Completes as a 1-cycle op with `result`=0 and `illegal`=1.
- All arithmetic is modulo 2^XLEN. SLT/SLTU return 0 or 1, zero-extended.
- MUL family:
  - Signed operands are converted to magnitudes; sign = sign(a)^sign(b) for signed ops.
  - 2·XLEN-bit shift-add runs over XLEN iterations.
  - A fix-up cycle negates the product if the sign is negative.
  - MUL returns the low half. MULH, MULHSU and MULHU return the high half.
- DIV family:
  - Restoring divider on magnitudes.
  - Quotient sign = sign(a)^sign(b); remainder sign = sign(a).
  - Special cases complete in 1 cycle with no iteration:
    - b=0 → quotient all-ones, remainder = a.
    - Signed a=−2^(XLEN−1), b=−1 → quotient = a, remainder = 0.
- FSM states: IDLE, ITER, FIXUP, DONE.
  - IDLE→DONE on `start` with a 1-cycle op or a special case; `result` is registered on the same edge.
  - IDLE→ITER on `start` with an iterative op. Operands, op and signs are latched; the counter is loaded with XLEN−1.
  - ITER→ITER while counter≠0, decrementing the counter. ITER→FIXUP when counter=0.
  - FIXUP→DONE; sign correction is applied and `result` is written.
  - DONE→IDLE unconditionally. `done`=1 only in DONE.
- Input operands may change after the accepting edge without effect.

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, `result`=0, `illegal`=0, counter and internal accumulators 0.
- Let `start` be accepted at edge E0.
- 1-cycle op: `done` is high in the cycle after E0 (latency 1). `busy`=1 in that same cycle.
- Iterative op:
  - ITER occupies XLEN cycles and FIXUP occupies 1.
  - `done` is high in cycle XLEN+2 after E0.
  - `busy` is high from E0 until the edge that leaves DONE.
- Back-to-back issue: the earliest next `start` is accepted at the edge that leaves DONE. `start` during DONE is ignored.
- `start` while `busy`=1 is dropped; there is no queueing.
- `rst` mid-operation: IDLE on the next edge, all outputs return to reset values, and no `done` is produced.
- `result` and `illegal` are stable and held until the next accepted `start`.

## Test plan
- XLEN=32, ALUOp=10, funct3=000, funct7=0100000, op=0110011, a=5, b=7 → `done` 1 cycle after E0, `result`=0xFFFFFFFE. Repeat with op=0010011 → `result`=12.
- funct3=101, funct7=0100000, a=0x80000000, b=4 → `result`=0xF8000000. With funct7=0000000 → `result`=0x08000000.
- MULH, a=0xFFFFFFFF (−1), b=0x00000002 → `done` 34 cycles after E0, `result`=0xFFFFFFFF. MULHU with the same operands → `result`=0x00000001. MUL with the same operands → `result`=0xFFFFFFFE.
- Division:
  - DIV a=−7, b=2 → `result`=0xFFFFFFFD (−3), latency 34. REM with the same operands → 0xFFFFFFFF (−1).
  - DIVU a=100, b=0 → `result`=0xFFFFFFFF, latency 1.
  - DIV a=0x80000000, b=0xFFFFFFFF → `result`=0x80000000, latency 1.
- Start DIVU a=1000, b=3 and assert `rst` at cycle 10 → outputs 0, no `done`. A new ADD `start` two cycles later completes normally. A `start` pulsed at cycle 5 of an iterative op is ignored and the original result is still 333.
- ALUOp=11 → `done` after 1 cycle with `illegal`=1 and `result`=0. ALUOp=10, funct7=0000010, op=0110011 → `illegal`=1.
